call_return_ctrl: RTL and testbench
===================================

# call_return_ctrl

Return-address controller that drives the 8-deep, 12-bit hardware return stack from the call/return side of the single-cycle MIPS datapath. On a decoded call it pushes the return address. On a decoded return it pops the stack, waits for the stack's registered read data, and presents a one-cycle PC redirect while stalling fetch. A shadow depth counter catches underflow and overflow before they reach the stack.

## Interface
- ADDR_W, 12, return-address width; must equal the stack's data width.
- DEPTH, 8, stack entry count; must equal the stack depth.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- call_req  in  1  decoded call (JAL) this cycle.
- ret_req  in  1  decoded return (JR $ra) this cycle.
- pc_plus1  in  ADDR_W  return address to push on call.
- push_sig  out  1  to stack; registered.
- pop_sig  out  1  to stack; registered.
- push_data  out  ADDR_W  to stack; registered.
- pop_data  in  ADDR_W  from stack; valid the cycle after the stack samples pop_sig.
- overflow  in  1  from stack.
- stall  out  1  freeze fetch/PC update.
- redirect_valid  out  1  one-cycle strobe; load PC from pc_redirect.
- pc_redirect  out  ADDR_W  popped return address; registered.
- depth  out  $clog2(DEPTH+1)  shadow occupancy, 0..DEPTH.
- ovf_err  out  1  sticky overflow flag.
- unf_err  out  1  one-cycle underflow pulse.

## Operation
- States: IDLE, POP, WAIT, REDIR. Reset state is IDLE.
- Reset values:
  - push_sig, pop_sig, push_data, pc_redirect, depth: 0.
  - redirect_valid, ovf_err, unf_err, stall: 0.
- Requests are accepted only in IDLE. In POP, WAIT and REDIR, call_req and ret_req are ignored and not queued; upstream holds the instruction under stall.
- If ret_req and call_req are both high in IDLE, ret wins and call is dropped.
- Call accepted in IDLE:
  - Normal case (depth<DEPTH): next edge sets push_sig=1 (one cycle), push_data=pc_plus1, depth+1.
  - depth==DEPTH: push is suppressed, depth unchanged, ovf_err set.
  - Calls need no stall, so back-to-back calls push on consecutive cycles.
- Return accepted in IDLE:
  - With depth>0: stall=1 combinationally that cycle. Next edge moves to POP with pop_sig=1 (one cycle) and depth-1.
  - POP -> WAIT: stack updates pop_data.
  - WAIT -> REDIR: pc_redirect<=pop_data.
  - REDIR: redirect_valid=1, stall=0, then back to IDLE.
- Return with depth==0: no pop_sig, no redirect, no stall; unf_err=1 for the following cycle.
- ovf_err is set by an internally suppressed push or by overflow=1 from the stack. It is cleared only by rst.
- Reset mid-operation forces IDLE and zeros everything immediately; the pending pop/redirect is lost. rst is asserted together with stack initialisation.

## Timing
- stall = (IDLE & ret_req & depth>0) | POP | WAIT.
- Call: push_sig high in cycle N+1 after call_req in cycle N.
- Return: ret_req at cycle N gives:
  - pop_sig high in N+1.
  - stall high in N, N+1, N+2.
  - redirect_valid high in N+3, with pc_redirect valid.
- The earliest next request is accepted in cycle N+4.
- depth updates on the same edge that raises push_sig/pop_sig.

## Configuration
- CALLRET_GUARD_EN defined: the depth counter, overflow suppression, underflow detection, ovf_err and unf_err are all as above.
- Undefined:
  - Pushes and pops are issued unconditionally.
  - depth, ovf_err and unf_err are tied to 0.
  - A return on an empty stack still runs the full sequence and redirects to the stale pop_data.

## Test plan
- Reset: assert rst mid-run -> all outputs 0 within the same cycle; state returns to IDLE.
- Single call/return:
  - Stimulus: call with pc_plus1=0x123, then ret.
  - push_sig at +1 with push_data=0x123, depth=1.
  - pop_sig at +1 after ret; stall for 3 cycles.
  - redirect_valid at +3 with pc_redirect=0x123; depth=0.
- Nesting: calls 0x010, 0x020, 0x030 then three rets -> redirects 0x030, 0x020, 0x010 in order; final depth=0.
- Overflow: 9 consecutive calls -> 8 push_sig pulses, 9th suppressed, depth=8, ovf_err=1 held until rst.
- Underflow: ret at depth 0 -> no pop_sig, stall stays 0, unf_err pulses once, no redirect_valid.
- Collision/busy:
  - call_req+ret_req with depth=2 -> pop only, depth=1.
  - call_req during WAIT -> ignored, depth unchanged.
  - rst in WAIT -> no redirect_valid afterwards.

Source files
------------

// File: rtl/call_return_ctrl.sv
// Return-address controller: pushes return addresses on calls, pops and redirects the PC on returns.
// Define CALLRET_GUARD_EN to enable the shadow depth counter with overflow/underflow protection.
module call_return_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         call_req,
    input  logic                         ret_req,
    input  logic [ADDR_W-1:0]            pc_plus1,
    output logic                         push_sig,
    output logic                         pop_sig,
    output logic [ADDR_W-1:0]            push_data,
    input  logic [ADDR_W-1:0]            pop_data,
    input  logic                         overflow,
    output logic                         stall,
    output logic                         redirect_valid,
    output logic [ADDR_W-1:0]            pc_redirect,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

`ifdef CALLRET_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, POP, WAIT, REDIR} state_t;

    state_t              state_q, state_d;
    logic                push_d, pop_d, redir_d, unf_d, ovf_d;
    logic [ADDR_W-1:0]   push_data_d, pc_redirect_d;
    logic [DEPTH_W-1:0]  depth_d;
    logic                has_entry, has_room;

    // Without the guard every push/pop is forwarded to the stack unconditionally
    assign has_entry = !GUARD || (depth != '0);
    assign has_room  = !GUARD || (depth != DEPTH_W'(DEPTH));

    // Next-state, next-output and combinational stall
    always_comb begin
        state_d       = state_q;
        push_d        = 1'b0;
        pop_d         = 1'b0;
        redir_d       = 1'b0;
        unf_d         = 1'b0;
        ovf_d         = ovf_err | overflow;
        push_data_d   = push_data;
        pc_redirect_d = pc_redirect;
        depth_d       = depth;
        stall         = 1'b0;
        case (state_q)
            IDLE: begin
                if (ret_req) begin
                    if (has_entry) begin
                        stall   = 1'b1;
                        pop_d   = 1'b1;
                        depth_d = depth - DEPTH_W'(1);
                        state_d = POP;
                    end else begin
                        unf_d = 1'b1;
                    end
                end else if (call_req) begin
                    if (has_room) begin
                        push_d      = 1'b1;
                        push_data_d = pc_plus1;
                        depth_d     = depth + DEPTH_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            POP: begin
                stall   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                stall         = 1'b1;
                pc_redirect_d = pop_data;
                redir_d       = 1'b1;
                state_d       = REDIR;
            end
            REDIR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            push_sig       <= 1'b0;
            pop_sig        <= 1'b0;
            push_data      <= '0;
            pc_redirect    <= '0;
            redirect_valid <= 1'b0;
            depth          <= '0;
            ovf_err        <= 1'b0;
            unf_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            push_sig       <= push_d;
            pop_sig        <= pop_d;
            push_data      <= push_data_d;
            pc_redirect    <= pc_redirect_d;
            redirect_valid <= redir_d;
            depth          <= GUARD ? depth_d : '0;
            ovf_err        <= GUARD & ovf_d;
            unf_err        <= GUARD & unf_d;
        end
    end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural return stack and a redirect scoreboard.
module tb_call_return_ctrl;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

`ifdef CALLRET_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                call_req, ret_req;
    logic [ADDR_W-1:0]   pc_plus1;
    logic                push_sig, pop_sig;
    logic [ADDR_W-1:0]   push_data;
    logic [ADDR_W-1:0]   pop_data;
    logic                overflow;
    logic                stall, redirect_valid;
    logic [ADDR_W-1:0]   pc_redirect;
    logic [DEPTH_W-1:0]  depth;
    logic                ovf_err, unf_err;

    int vectors    = 0;
    int miscompares = 0;
    int md         = 0;
    bit ovf_exp    = 1'b0;
    logic [ADDR_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    call_return_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .pc_plus1(pc_plus1), .push_sig(push_sig), .pop_sig(pop_sig),
        .push_data(push_data), .pop_data(pop_data), .overflow(overflow),
        .stall(stall), .redirect_valid(redirect_valid), .pc_redirect(pc_redirect),
        .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // Behavioural 8-deep stack: registered read data, overflow pulse on push when full
    logic [ADDR_W-1:0] mem [DEPTH];
    int                sp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp       <= 0;
            pop_data <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (push_sig) begin
                if (sp < DEPTH) begin
                    mem[sp] <= push_data;
                    sp      <= sp + 1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (pop_sig && sp > 0) begin
                pop_data <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each redirect must match the oldest expected return address
    always @(negedge clk) begin
        if (!rst && redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", 32'(redirect_valid), 32'(0));
            end else begin
                chk("pc_redirect", 32'(pc_redirect), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_push_sig"}, 32'(push_sig), 0);
        chk({tag, "_pop_sig"}, 32'(pop_sig), 0);
        chk({tag, "_push_data"}, 32'(push_data), 0);
        chk({tag, "_pc_redirect"}, 32'(pc_redirect), 0);
        chk({tag, "_depth"}, 32'(depth), 0);
        chk({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
        chk({tag, "_ovf_err"}, 32'(ovf_err), 0);
        chk({tag, "_unf_err"}, 32'(unf_err), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
    endtask

    task automatic do_call(input logic [ADDR_W-1:0] addr);
        bit exp_push;
        exp_push = !G || (md < DEPTH);
        if (G && exp_push) md++;
        if (G && !exp_push) ovf_exp = 1'b1;
        call_req = 1'b1;
        pc_plus1 = addr;
        #1;
        chk("call_stall", 32'(stall), 0);
        tick();
        call_req = 1'b0;
        chk("call_push_sig", 32'(push_sig), 32'(exp_push));
        if (exp_push) chk("call_push_data", 32'(push_data), 32'(addr));
        chk("call_depth", 32'(depth), 32'(md));
        chk("call_ovf_err", 32'(ovf_err), 32'(ovf_exp));
    endtask

    task automatic do_ret(input logic [ADDR_W-1:0] addr);
        if (G && md == 0) begin
            ret_req = 1'b1;
            #1;
            chk("unf_stall", 32'(stall), 0);
            tick();
            ret_req = 1'b0;
            chk("unf_pop_sig", 32'(pop_sig), 0);
            chk("unf_err_pulse", 32'(unf_err), 1);
            chk("unf_stall_after", 32'(stall), 0);
            tick();
            chk("unf_err_clear", 32'(unf_err), 0);
            chk("unf_no_redirect", 32'(redirect_valid), 0);
        end else begin
            if (G) md--;
            exp_q.push_back(addr);
            ret_req = 1'b1;
            #1;
            chk("ret_stall_n", 32'(stall), 1);
            tick();
            ret_req = 1'b0;
            chk("ret_pop_sig", 32'(pop_sig), 1);
            chk("ret_stall_n1", 32'(stall), 1);
            chk("ret_depth", 32'(depth), 32'(md));
            tick();
            chk("ret_pop_sig_clear", 32'(pop_sig), 0);
            chk("ret_stall_n2", 32'(stall), 1);
            tick();
            chk("ret_stall_n3", 32'(stall), 0);
            chk("ret_redirect_valid", 32'(redirect_valid), 1);
            tick();
            chk("ret_redirect_clear", 32'(redirect_valid), 0);
        end
    endtask

    initial begin
        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0; pc_plus1 = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single call/return
        do_call(12'h123);
        tick();
        chk("push_single_pulse", 32'(push_sig), 0);
        do_ret(12'h123);
        chk("single_final_depth", 32'(depth), 0);

        // Nesting, back-to-back calls
        do_call(12'h010);
        do_call(12'h020);
        do_call(12'h030);
        do_ret(12'h030);
        do_ret(12'h020);
        do_ret(12'h010);
        chk("nest_final_depth", 32'(depth), 0);

        // Overflow: nine consecutive calls
        for (int i = 0; i < 9; i++) do_call(ADDR_W'(12'h100 + i));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_err_held", 32'(ovf_err), 32'(ovf_exp));
        end
        rst = 1'b1;
        #1;
        chk_all_zero("ovf_reset");
        tick();
        rst = 1'b0; md = 0; ovf_exp = 1'b0;
        tick();

        // Underflow (without the guard: full sequence redirecting to stale pop_data)
        do_ret(pop_data);
        chk("unf_depth", 32'(depth), 0);

        // Collision: ret wins over call at depth 2
        do_call(12'h040);
        do_call(12'h050);
        if (G) md--;
        exp_q.push_back(12'h050);
        call_req = 1'b1; ret_req = 1'b1; pc_plus1 = 12'h060;
        #1;
        chk("coll_stall", 32'(stall), 1);
        tick();
        call_req = 1'b0; ret_req = 1'b0;
        chk("coll_pop_sig", 32'(pop_sig), 1);
        chk("coll_push_sig", 32'(push_sig), 0);
        chk("coll_depth", 32'(depth), 32'(md));
        tick();
        // WAIT: call must be ignored
        call_req = 1'b1; pc_plus1 = 12'h070;
        #1;
        chk("wait_stall", 32'(stall), 1);
        tick();
        call_req = 1'b0;
        chk("busy_redirect", 32'(redirect_valid), 1);
        chk("busy_push_sig", 32'(push_sig), 0);
        tick();
        chk("busy_call_ignored", 32'(push_sig), 0);
        chk("busy_depth", 32'(depth), 32'(md));

        // Reset while in WAIT loses the pending redirect
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        tick();
        chk("rstwait_stall", 32'(stall), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_in_wait");
        tick();
        rst = 1'b0; md = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstwait_no_redirect", 32'(redirect_valid), 0);
            chk("rstwait_no_stall", 32'(stall), 0);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
